// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared types and constants for the ALU datapath blocks.
//   - swa_state_t     : control states of the serial wide adder
//   - SLICE_W_DEFAULT : default slice width of the serial wide adder
package alu_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } swa_state_t;

  localparam int SLICE_W_DEFAULT = 4;

endpackage : alu_pkg

// File: rtl/op_suma.sv
// OpSuma
//   N-bit ripple-carry slice adder: Sum = A + B + Cin.
//   Ports:
//     A, B  in  N  addends
//     Cin   in  1  carry into bit 0
//     Sum   out N  sum bits
//     Cout  out 1  carry out of bit N-1
//     v     out 1  signed overflow of this slice taken on its own
module OpSuma #(
  parameter int N = 4
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] Sum,
  output logic         Cout,
  output logic         v
);

  always_comb begin
    logic [N:0] c;
    // NOTE: every combinational output gets a value before any branch or loop
    // touches it, so no path can leave it unassigned and infer a latch.
    c   = '0;
    Sum = '0;
    c[0] = Cin;
    for (int i = 0; i < N; i++) begin
      Sum[i]   = A[i] ^ B[i] ^ c[i];
      c[i + 1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
    Cout = c[N];
    // Overflow: carry into the sign bit differs from carry out of it.
    v    = c[N] ^ c[N - 1];
  end

endmodule : OpSuma

// File: rtl/serial_wide_adder.sv
// serial_wide_adder
//   Adds two W-bit operands (W = N*WORDS) by passing one N-bit slice per
//   cycle, LSB slice first, through a single OpSuma slice adder. The carry
//   out of each slice is registered and fed into the next slice.
//   Ports:
//     clk    in   1  rising-edge clock
//     rst_n  in   1  synchronous active-low reset
//     start  in   1  request, accepted while ready=1
//     a, b   in   W  operands, captured on the accepting edge
//     cin    in   1  carry into slice 0, captured on the accepting edge
//     ready  out  1  idle or done; a start is accepted
//     busy   out  1  slices being processed
//     done   out  1  one-cycle pulse, result valid
//     sum    out  W  result, held until the next done
//     cout   out  1  carry out of the top slice
//     v      out  1  signed overflow of the full-width add
//     z      out  1  result is zero
module serial_wide_adder
  import alu_pkg::*;
#(
  parameter int N     = SLICE_W_DEFAULT,
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [N*WORDS-1:0] a,
  input  logic [N*WORDS-1:0] b,
  input  logic               cin,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [N*WORDS-1:0] sum,
  output logic               cout,
  output logic               v,
  output logic               z
);

  localparam int W  = N * WORDS;
  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

  swa_state_t    state, state_nx;
  logic [KW-1:0] k;
  logic [W-1:0]  a_q, b_q;
  logic          cin_q;
  logic          carry_q;
  logic [W-1:0]  acc_q;      // working sum, built up slice by slice

  logic [N-1:0]  slice_a, slice_b, slice_sum;
  logic          slice_cin, slice_cout;
  logic [W-1:0]  merged_sum; // acc_q with the current slice result inserted
  logic          accept;

  assign ready  = (state != S_RUN);
  assign busy   = (state == S_RUN);
  assign done   = (state == S_DONE);
  assign accept = ready && start;

  always_comb begin
    slice_a   = a_q[k*N +: N];
    slice_b   = b_q[k*N +: N];
    // Slice 0 takes the captured carry-in; later slices take the chained carry.
    slice_cin = (k == '0) ? cin_q : carry_q;
  end

  always_comb begin
    merged_sum             = acc_q;
    merged_sum[k*N +: N]   = slice_sum;
  end

  OpSuma #(.N(N)) u_slice (
    .A    (slice_a),
    .B    (slice_b),
    .Cin  (slice_cin),
    .Sum  (slice_sum),
    .Cout (slice_cout),
    .v    ()
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN:   if (k == K_LAST) state_nx = S_DONE;
      S_DONE:  state_nx = start ? S_RUN : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!rst_n) begin
      state   <= S_IDLE;
      k       <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      v       <= 1'b0;
      z       <= 1'b0;
      // NOTE: the operand copies are deliberately not reset; they are only
      // read in RUN, which is always entered through an accept that loads them.
    end else begin
      state <= state_nx;
      if (accept) begin
        a_q   <= a;
        b_q   <= b;
        cin_q <= cin;
        k     <= '0;
        acc_q <= '0;
      end else if (state == S_RUN) begin
        acc_q   <= merged_sum;
        carry_q <= slice_cout;
        if (k == K_LAST) begin
          // Publish the result only now, so the previous result stays
          // visible for the whole of a back-to-back run.
          sum  <= merged_sum;
          cout <= slice_cout;
          v    <= (a_q[W-1] == b_q[W-1]) && (merged_sum[W-1] != a_q[W-1]);
          z    <= (merged_sum == '0);
        end else begin
          k <= k + 1'b1;
        end
      end
    end
  end

endmodule : serial_wide_adder

// File: tb/tb_serial_wide_adder.sv
// tb_serial_wide_adder
//   Directed vectors for serial_wide_adder (N=4, WORDS=4). Stimulus pushes
//   the hand-computed result and its due cycle into a scoreboard queue; an
//   independent monitor pops and compares on every done pulse.
module tb_serial_wide_adder;

  localparam int N     = 4;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         ready, busy, done, cout, v, z;
  logic [W-1:0] sum;

  serial_wide_adder #(.N(N), .WORDS(WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .v     (v),
    .z     (z)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         v;
    logic         z;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done !== 1'b0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=%b expected=0 (cycle %0d)", done, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("res_sum",     32'(sum),  32'(e.sum));
        check("res_cout",    32'(cout), 32'(e.cout));
        check("res_v",       32'(v),    32'(e.v));
        check("res_z",       32'(z),    32'(e.z));
        check("res_latency", 32'(cyc),  32'(e.cyc));
      end
    end
  end

  // Wait for ready, present one request, and optionally expect its result.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                       input logic push, input logic [W-1:0] es,
                       input logic ec, input logic ev, input logic ez);
    int n;
    n = 0;
    @(negedge clk);
    while (ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_timeout", 32'(ready), 32'd1);
    a     = ta;
    b     = tb;
    cin   = tc;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (push) sb.push_back('{es, ec, ev, ez, cyc + WORDS});
    start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_sum",   32'(sum),   32'd0);
    check("rst_flags", {29'd0, cout, v, z}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors: a, b, cin, expected sum, cout, v, z
    do_op(16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b0, 1'b0); drain();
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1); drain();
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0); drain();
    do_op(16'h8000, 16'h8000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1); drain();
    do_op(16'h0000, 16'hFFFF, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1); drain();

    // start and operand changes during RUN are ignored
    do_op(16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("run_busy", 32'(busy), 32'd1);
    a = 16'hAAAA; b = 16'h5555; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Reset at k=2 aborts the operation without a done
    do_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy",  32'(busy),  32'd0);
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_sum",   32'(sum),   32'd0);
    check("abort_done",  32'(done),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    do_op(16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b0, 1'b0);

    // start held high into DONE: immediate re-accept, old result held
    a = 16'h0F0F; b = 16'h0101; cin = 1'b0; start = 1'b1;
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (done !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n >= 20) check("b2b_done_timeout", 32'(done), 32'd1);
    end
    @(posedge clk);
    #1;
    check("b2b_run_entered", 32'(busy), 32'd1);
    check("b2b_prior_held",  32'(sum),  32'h5555);
    sb.push_back('{16'h1010, 1'b0, 1'b0, 1'b0, cyc + WORDS});
    start = 1'b0;
    drain();

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_serial_wide_adder
